h80bus_arbiter: RTL and testbench

Two-master arbiter and transaction sequencer for the h80 bus. It sits between the h80cpu (master 0) and a second bus master such as the UART loader or debug DMA (master 1), and the shared memory/IO slaves. It grants the bus round-robin and drives `mreq_n`/`iorq_n`, address, command and write data for one transaction at a time. It completes each transaction on `bus_wait_n`, or aborts it with an error after a timeout.

---
 rtl/h80bus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_h80bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/h80bus_arbiter.sv
// ---------------------------------------------------------------------------
// h80bus_arbiter
//
// Two-master arbiter and transaction sequencer for the h80 bus. Master 0 is
// the h80cpu, master 1 is a secondary master (UART loader, debug DMA). One
// transaction runs at a time: IDLE picks a winner round-robin and launches
// the bus cycle, WAIT holds the bus until the slave releases bus_wait_n (or
// the timeout expires), DONE pulses the winner's done and returns to IDLE.
//
// Ports
//   clk, reset               single rising-edge clock, synchronous active-high reset
//   mX_req                   request, held by the master until its done
//   mX_io                    1 = IO space (iorq_n), 0 = memory space (mreq_n)
//   mX_addr/cmd/wdata        transaction address, command, write data
//   mX_gnt                   high for the whole granted transaction
//   mX_done                  one-cycle completion pulse
//   mX_err                   valid with done; 1 = aborted by timeout
//   mX_rdata                 captured read data, held until the next done
//   mreq_n, iorq_n           active-low slave strobes, never both low
//   bus_addr/cmd/wdata       registered bus fields of the current transaction
//   bus_rdata                slave read data
//   bus_wait_n               low while the slave is stalling
// ---------------------------------------------------------------------------
module h80bus_arbiter #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int WAIT_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic                      m0_io,
  input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
  input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
  input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
  output logic                      m0_gnt,
  output logic                      m0_done,
  output logic                      m0_err,
  output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_io,
  input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
  input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
  input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
  output logic                      m1_gnt,
  output logic                      m1_done,
  output logic                      m1_err,
  output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
  output logic                      mreq_n,
  output logic                      iorq_n,
  output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  output logic [BUS_CMD_WIDTH-1:0]  bus_cmd,
  output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
  input  logic [BUS_DATA_WIDTH-1:0] bus_rdata,
  input  logic                      bus_wait_n
);

  // Counter only has to reach WAIT_TIMEOUT; the FSM leaves WAIT when it
  // does, so the counter can never increment past that value.
  localparam int CntWidth = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_q;
  logic                      last_q;
  logic                      win_q;
  logic [CntWidth-1:0]       cnt_q;
  logic                      mreq_n_q;
  logic                      iorq_n_q;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr_q;
  logic [BUS_CMD_WIDTH-1:0]  bus_cmd_q;
  logic [BUS_DATA_WIDTH-1:0] bus_wdata_q;
  logic                      m0_gnt_q;
  logic                      m1_gnt_q;
  logic                      m0_done_q;
  logic                      m1_done_q;
  logic                      m0_err_q;
  logic                      m1_err_q;
  logic [BUS_DATA_WIDTH-1:0] m0_rdata_q;
  logic [BUS_DATA_WIDTH-1:0] m1_rdata_q;

  logic                      win_d;
  logic                      sel_io_d;
  logic [BUS_ADDR_WIDTH-1:0] sel_addr_d;
  logic [BUS_CMD_WIDTH-1:0]  sel_cmd_d;
  logic [BUS_DATA_WIDTH-1:0] sel_wdata_d;

  // Round-robin: a lone requester wins; on a tie the master that was not
  // granted last wins. last_q resets to 1 so master 0 takes the first tie.
  always_comb begin
    win_d = 1'b0;
    if (m0_req && m1_req) begin
      win_d = ~last_q;
    end else if (m1_req) begin
      win_d = 1'b1;
    end
  end

  // Transaction fields of the selected master, latched at grant.
  always_comb begin
    sel_io_d    = m0_io;
    sel_addr_d  = m0_addr;
    sel_cmd_d   = m0_cmd;
    sel_wdata_d = m0_wdata;
    if (win_d) begin
      sel_io_d    = m1_io;
      sel_addr_d  = m1_addr;
      sel_cmd_d   = m1_cmd;
      sel_wdata_d = m1_wdata;
    end
  end

  // Sequencer FSM. done is a one-cycle pulse, so it defaults low every
  // cycle. Bus address/command/data are left untouched after completion;
  // only the strobes return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      cnt_q       <= '0;
      mreq_n_q    <= 1'b1;
      iorq_n_q    <= 1'b1;
      bus_addr_q  <= '0;
      bus_cmd_q   <= '0;
      bus_wdata_q <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            win_q       <= win_d;
            last_q      <= win_d;
            bus_addr_q  <= sel_addr_d;
            bus_cmd_q   <= sel_cmd_d;
            bus_wdata_q <= sel_wdata_d;
            mreq_n_q    <= sel_io_d;
            iorq_n_q    <= ~sel_io_d;
            m0_gnt_q    <= ~win_d;
            m1_gnt_q    <= win_d;
            cnt_q       <= '0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Completion and timeout abort share one path; only the data
          // captured and the err flag differ.
          if (bus_wait_n || (cnt_q == TimeoutVal)) begin
            if (win_q) begin
              m1_rdata_q <= bus_wait_n ? bus_rdata : '1;
              m1_err_q   <= ~bus_wait_n;
              m1_done_q  <= 1'b1;
            end else begin
              m0_rdata_q <= bus_wait_n ? bus_rdata : '1;
              m0_err_q   <= ~bus_wait_n;
              m0_done_q  <= 1'b1;
            end
            mreq_n_q <= 1'b1;
            iorq_n_q <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          m0_gnt_q <= 1'b0;
          m1_gnt_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mreq_n    = mreq_n_q;
  assign iorq_n    = iorq_n_q;
  assign bus_addr  = bus_addr_q;
  assign bus_cmd   = bus_cmd_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_h80bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_h80bus_arbiter
//
// Directed bench for h80bus_arbiter with WAIT_TIMEOUT = 4. Stimulus pushes
// the expected completion (master, rdata, err, latency) into a scoreboard
// queue; a monitor on the falling edge pops an entry whenever a done pulse
// appears. A small slave model stalls bus_wait_n for a programmable number
// of strobe cycles.
// ---------------------------------------------------------------------------
module tb_h80bus_arbiter;

  localparam int Timeout = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_io = 1'b0, m1_io = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [2:0]  m0_cmd = '0, m1_cmd = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mreq_n, iorq_n;
  logic [15:0] bus_addr;
  logic [2:0]  bus_cmd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_wait_n = 1'b1;

  typedef struct {
    int          master;
    logic [31:0] rdata;
    logic        err;
    int          issueCyc;
    int          expLat;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   slaveWaits = 0;
  int   lowCnt = 0;

  h80bus_arbiter #(
    .BUS_ADDR_WIDTH(16),
    .BUS_CMD_WIDTH (3),
    .BUS_DATA_WIDTH(32),
    .WAIT_TIMEOUT  (Timeout)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_io     (m0_io),
    .m0_addr   (m0_addr),
    .m0_cmd    (m0_cmd),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_done   (m0_done),
    .m0_err    (m0_err),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_io     (m1_io),
    .m1_addr   (m1_addr),
    .m1_cmd    (m1_cmd),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_done   (m1_done),
    .m1_err    (m1_err),
    .m1_rdata  (m1_rdata),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .bus_addr  (bus_addr),
    .bus_cmd   (bus_cmd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_wait_n(bus_wait_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: holds bus_wait_n low for the first slaveWaits cycles of each strobe.
  always @(negedge clk) begin
    if (!mreq_n || !iorq_n) begin
      bus_wait_n = (lowCnt >= slaveWaits);
      lowCnt++;
    end else begin
      lowCnt = 0;
      bus_wait_n = 1'b1;
    end
  end

  // Monitor: strobe exclusivity every cycle, scoreboard pop on every done.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("strobe_exclusive", 64'(mreq_n | iorq_n), 64'(1));
    end
    if (m0_done || m1_done) begin
      checkOutput("single_done", 64'(m0_done & m1_done), 64'(0));
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 64'(m1_done), 64'(2));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("done_master", 64'(m1_done), 64'(e.master));
        checkOutput("done_rdata", 64'(m1_done ? m1_rdata : m0_rdata), 64'(e.rdata));
        checkOutput("done_err", 64'(m1_done ? m1_err : m0_err), 64'(e.err));
        if (e.expLat >= 0) begin
          checkOutput("done_latency", 64'(cyc - e.issueCyc), 64'(e.expLat));
        end
      end
    end
  end

  // One transaction from a single master; counts strobe-low cycles and
  // checks that the bus fields stay put while the strobe is active.
  task automatic applyStimulus(input int m, input logic io, input logic [15:0] addr,
                               input logic [2:0] cmd, input logic [31:0] wdata,
                               input int waits, input logic [31:0] rdata,
                               input logic expErr, input logic [31:0] expRdata,
                               input int expLat, input int expMreq, input int expIorq);
    int mreqCnt, iorqCnt, bad;
    logic seen;
    @(negedge clk);
    slaveWaits = waits;
    bus_rdata  = rdata;
    sbq.push_back('{m, expRdata, expErr, cyc, expLat});
    if (m == 0) begin
      m0_io = io; m0_addr = addr; m0_cmd = cmd; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_io = io; m1_addr = addr; m1_cmd = cmd; m1_wdata = wdata; m1_req = 1'b1;
    end
    mreqCnt = 0; iorqCnt = 0; bad = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!mreq_n) mreqCnt++;
      if (!iorq_n) iorqCnt++;
      if ((!mreq_n || !iorq_n) && (bus_wdata !== wdata || bus_addr !== addr || bus_cmd !== cmd))
        bad++;
      if (m == 0 ? m0_done : m1_done) seen = 1'b1;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    checkOutput("done_seen", 64'(seen), 64'(1));
    checkOutput("mreq_low_cycles", 64'(mreqCnt), 64'(expMreq));
    checkOutput("iorq_low_cycles", 64'(iorqCnt), 64'(expIorq));
    checkOutput("bus_fields_stable", 64'(bad), 64'(0));
  endtask

  initial begin
    int doneCnt;
    $display("[TB] start");

    // Reset with both masters requesting.
    m0_req = 1'b1; m0_io = 1'b0; m0_addr = 16'h0100; m0_wdata = 32'h0000_0A0A;
    m1_req = 1'b1; m1_io = 1'b1; m1_addr = 16'h0200; m1_wdata = 32'h0000_0B0B;
    slaveWaits = 1;
    bus_rdata  = 32'h5A5A_1234;
    repeat (3) @(negedge clk);
    checkOutput("rst_mreq_n", 64'(mreq_n), 64'(1));
    checkOutput("rst_iorq_n", 64'(iorq_n), 64'(1));
    checkOutput("rst_bus", {bus_wdata, bus_addr, 13'(bus_cmd)}, 64'(0));
    checkOutput("rst_rdata", {m0_rdata, m1_rdata}, 64'(0));
    checkOutput("rst_flags", 64'({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err}), 64'(0));

    // Continuous requests from both: six alternating grants, m0 first.
    for (int i = 0; i < 6; i++) sbq.push_back('{i % 2, 32'h5A5A_1234, 1'b0, 0, -1});
    reset = 1'b0;
    @(negedge clk);
    checkOutput("first_gnt", 64'({m0_gnt, m1_gnt}), 64'(2'b10));
    doneCnt = 0;
    for (int i = 0; i < 60 && doneCnt < 6; i++) begin
      if (m0_done || m1_done) doneCnt++;
      if (doneCnt < 6) @(negedge clk);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    checkOutput("rr_done_count", 64'(doneCnt), 64'(6));

    // m0 memory read, no wait states.
    applyStimulus(0, 1'b0, 16'h1234, 3'd1, 32'h0, 0, 32'hDEAD_BEEF,
                  1'b0, 32'hDEAD_BEEF, 2, 1, 0);

    // m1 IO write with three wait states.
    applyStimulus(1, 1'b1, 16'h0010, 3'd2, 32'hCAFE_F00D, 3, 32'h1111_2222,
                  1'b0, 32'h1111_2222, 5, 0, 4);
    checkOutput("m0_rdata_held", 64'(m0_rdata), 64'(32'hDEAD_BEEF));

    // Timeout abort, then a normal transaction with err cleared.
    applyStimulus(0, 1'b0, 16'h4000, 3'd1, 32'h0, 1000, 32'h3333_4444,
                  1'b1, 32'hFFFF_FFFF, Timeout + 2, Timeout + 1, 0);
    applyStimulus(0, 1'b0, 16'h4004, 3'd1, 32'h0, 1, 32'h7777_8888,
                  1'b0, 32'h7777_8888, 3, 2, 0);

    // Reset in WAIT: strobes idle, grant dropped, no done.
    @(negedge clk);
    slaveWaits = 1000;
    m1_io = 1'b0; m1_addr = 16'h0042; m1_req = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_gnt", 64'({m1_gnt, mreq_n}), 64'(2'b10));
    @(negedge clk);
    reset = 1'b1;
    m1_req = 1'b0;
    @(negedge clk);
    checkOutput("midrst_strobes", 64'({mreq_n, iorq_n}), 64'(2'b11));
    checkOutput("midrst_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
    checkOutput("midrst_done", 64'({m0_done, m1_done}), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Normal operation resumes after reset.
    applyStimulus(1, 1'b1, 16'h0020, 3'd3, 32'h0BAD_F00D, 0, 32'h9999_AAAA,
                  1'b0, 32'h9999_AAAA, 2, 0, 1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
